// File: rtl/clb_cfg_loader_if.sv
// Serial configuration bus between the device bitstream shifter and one CLB config loader.
// The loader takes the slave view; the shifter side (or a bench) takes the master view.
interface clb_cfg_loader_if #(
  parameter int unsigned CFG_W = 37
);
  logic             DIN;
  logic             DVALID;
  logic             CLR;
  logic [CFG_W-1:0] CFG;
  logic             CFG_LOAD;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output DIN, DVALID, CLR,
    input  CFG, CFG_LOAD, BUSY, DONE, ERR
  );

  modport slave (
    input  DIN, DVALID, CLR,
    output CFG, CFG_LOAD, BUSY, DONE, ERR
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration writer: hunts for a preamble, shifts in one frame, checks even parity,
// and commits the frame to CFG atomically.
module clb_cfg_loader #(
  parameter int unsigned      CFG_W   = 37,
  parameter logic [7:0]       PRE     = 8'hB5,
  parameter int unsigned      TO_CYC  = 64,
  parameter logic [CFG_W-1:0] CFG_RST = 37'h3802A0116
) (
  input logic               K,
  input logic               RSTN,
  clb_cfg_loader_if.slave   bus
);

  localparam int unsigned BCNT_W = $clog2(CFG_W + 1);
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  state_t            state;
  logic [7:0]        win;
  logic [CFG_W-1:0]  shadow;
  logic [BCNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [CFG_W-1:0]  cfg;
  logic              cfg_load;
  logic              done;
  logic              err;

  logic [7:0]        win_nxt;
  logic [TO_W-1:0]   to_inc;
  logic              to_hit;
  logic              par_ok;

  // Preamble window including the current bit, saturating idle count, and parity result.
  assign win_nxt = {win[6:0], bus.DIN};
  assign to_inc  = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + TO_W'(1);
  assign to_hit  = (to_inc >= TO_W'(TO_CYC));
  assign par_ok  = ~(^shadow ^ bus.DIN);

  always_ff @(posedge K) begin
    if (!RSTN) begin
      state    <= S_HUNT;
      win      <= '0;
      shadow   <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      cfg      <= CFG_RST;
      cfg_load <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cfg_load <= 1'b0;
      // Clear first so a same-edge set below takes priority.
      if (bus.CLR) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        S_HUNT: begin
          if (bus.DVALID) begin
            if (win_nxt == PRE) begin
              state   <= S_DATA;
              win     <= '0;
              bit_cnt <= '0;
              to_cnt  <= '0;
            end else begin
              win <= win_nxt;
            end
          end
        end
        S_DATA: begin
          if (bus.DVALID) begin
            shadow <= {shadow[CFG_W-2:0], bus.DIN};
            to_cnt <= '0;
            if (bit_cnt == BCNT_W'(CFG_W - 1)) begin
              state <= S_PAR;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end else if (to_hit) begin
            err    <= 1'b1;
            state  <= S_HUNT;
            win    <= '0;
            shadow <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_PAR: begin
          if (bus.DVALID) begin
            if (par_ok) begin
              cfg      <= shadow;
              cfg_load <= 1'b1;
              done     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state  <= S_HUNT;
            win    <= '0;
            shadow <= '0;
            to_cnt <= '0;
          end else if (to_hit) begin
            err    <= 1'b1;
            state  <= S_HUNT;
            win    <= '0;
            shadow <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_inc;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

  assign bus.CFG      = cfg;
  assign bus.CFG_LOAD = cfg_load;
  assign bus.BUSY     = (state != S_HUNT);
  assign bus.DONE     = done;
  assign bus.ERR      = err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: reset value, good/bad frames, gaps, timeout, mid-frame reset
// and CLR/set priority.
module tb_clb_cfg_loader;

  localparam int unsigned CFG_W = 37;

  logic K;
  logic RSTN;
  int   total;
  int   bad;

  clb_cfg_loader_if #(.CFG_W(CFG_W)) bus ();

  clb_cfg_loader #(
    .CFG_W  (CFG_W),
    .PRE    (8'hB5),
    .TO_CYC (64),
    .CFG_RST(37'h3802A0116)
  ) dut (
    .K   (K),
    .RSTN(RSTN),
    .bus (bus)
  );

  initial K = 1'b0;
  always #5 K = ~K;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge K);
    #1;
  endtask

  // One accepted bit; returns 1 ns after the sampling edge.
  task automatic send_bit(input logic b);
    bus.DIN    = b;
    bus.DVALID = 1'b1;
    @(posedge K);
    #1;
    bus.DVALID = 1'b0;
    bus.DIN    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] data, input logic flip, input int gap,
                            input logic clr_par, output logic loaded, output int busy_low);
    logic par;
    busy_low = 0;
    send_byte(8'hB5, gap);
    for (int i = CFG_W - 1; i >= 0; i--) begin
      send_bit(data[i]);
      if (bus.BUSY !== 1'b1) busy_low++;
      for (int g = 0; g < gap; g++) begin
        idle(1);
        if (bus.BUSY !== 1'b1) busy_low++;
      end
    end
    par     = (^data) ^ flip;
    bus.CLR = clr_par;
    send_bit(par);
    bus.CLR = 1'b0;
    loaded  = bus.CFG_LOAD;
  endtask

  initial begin
    logic ld;
    int   bl;
    total      = 0;
    bad        = 0;
    bus.DIN    = 1'b0;
    bus.DVALID = 1'b0;
    bus.CLR    = 1'b0;
    RSTN       = 1'b0;

    // Reset held two cycles
    idle(2);
    check("rst_cfg", 64'(bus.CFG), 64'h3802A0116);
    check("rst_done", 64'(bus.DONE), 64'd0);
    check("rst_err", 64'(bus.ERR), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_load", 64'(bus.CFG_LOAD), 64'd0);
    RSTN = 1'b1;
    idle(1);

    // Good frame, continuous DVALID
    send_frame(37'h0_0000_FFFF, 1'b0, 0, 1'b0, ld, bl);
    check("good_load", 64'(ld), 64'd1);
    check("good_cfg", 64'(bus.CFG), 64'h0_0000_FFFF);
    check("good_done", 64'(bus.DONE), 64'd1);
    check("good_busy_payload", 64'(bl), 64'd0);
    check("good_busy_after", 64'(bus.BUSY), 64'd0);
    idle(1);
    check("load_pulse_end", 64'(bus.CFG_LOAD), 64'd0);

    // Bad parity, then a good frame still loads
    send_frame(37'h0_0000_FFFF, 1'b1, 0, 1'b0, ld, bl);
    check("badpar_load", 64'(ld), 64'd0);
    check("badpar_err", 64'(bus.ERR), 64'd1);
    check("badpar_cfg", 64'(bus.CFG), 64'h0_0000_FFFF);
    idle(2);
    send_frame(37'h12_3456_789A, 1'b0, 0, 1'b0, ld, bl);
    check("after_bad_load", 64'(ld), 64'd1);
    check("after_bad_cfg", 64'(bus.CFG), 64'h12_3456_789A);

    // CLR alone clears both sticky flags
    bus.CLR = 1'b1;
    idle(1);
    bus.CLR = 1'b0;
    check("clr_done", 64'(bus.DONE), 64'd0);
    check("clr_err", 64'(bus.ERR), 64'd0);

    // Leading noise then a frame with 3-cycle DVALID gaps
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_frame(37'h15_A5A5_C3C3, 1'b0, 3, 1'b0, ld, bl);
    check("gap_load", 64'(ld), 64'd1);
    check("gap_cfg", 64'(bus.CFG), 64'h15_A5A5_C3C3);
    check("gap_busy_payload", 64'(bl), 64'd0);
    check("gap_done", 64'(bus.DONE), 64'd1);

    // Timeout: 63 idle cycles tolerated, the 64th aborts
    send_byte(8'hB5, 0);
    for (int i = 0; i < 10; i++) send_bit(1'(i % 2));
    idle(63);
    check("to_63_err", 64'(bus.ERR), 64'd0);
    check("to_63_busy", 64'(bus.BUSY), 64'd1);
    idle(1);
    check("to_64_err", 64'(bus.ERR), 64'd1);
    check("to_64_busy", 64'(bus.BUSY), 64'd0);
    check("to_cfg", 64'(bus.CFG), 64'h15_A5A5_C3C3);

    // Reset mid-payload, fresh frame, then CLR on the same edge as a parity error
    send_byte(8'hB5, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    RSTN = 1'b0;
    idle(1);
    RSTN = 1'b1;
    check("midrst_cfg", 64'(bus.CFG), 64'h3802A0116);
    check("midrst_busy", 64'(bus.BUSY), 64'd0);
    check("midrst_done", 64'(bus.DONE), 64'd0);
    check("midrst_err", 64'(bus.ERR), 64'd0);
    send_frame(37'h0A_BCDE_F012, 1'b0, 0, 1'b0, ld, bl);
    check("fresh_load", 64'(ld), 64'd1);
    check("fresh_cfg", 64'(bus.CFG), 64'h0A_BCDE_F012);
    send_frame(37'h0A_BCDE_F012, 1'b1, 0, 1'b1, ld, bl);
    check("clr_vs_set_err", 64'(bus.ERR), 64'd1);
    check("clr_vs_set_done", 64'(bus.DONE), 64'd0);
    check("clr_vs_set_cfg", 64'(bus.CFG), 64'h0A_BCDE_F012);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
